// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline control types for the hazard sequencer
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } hz_state_e;

  // Per-stage register controls; a flush wins over the enable in the stage register.
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_flush;
  } stage_ctrl_t;

  // Everything advances, nothing squashed.
  localparam stage_ctrl_t STAGE_RUN = '{
    pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0, id_ex_en: 1'b1,
    id_ex_flush: 1'b0, ex_mem_en: 1'b1, mem_wb_flush: 1'b0};

  // Memory not ready: hold PC..EX/MEM and push a bubble into WB.
  localparam stage_ctrl_t STAGE_FREEZE = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b1};

  // Halted: every register holds.
  localparam stage_ctrl_t STAGE_HOLD = '{
    pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0, id_ex_en: 1'b0,
    id_ex_flush: 1'b0, ex_mem_en: 1'b0, mem_wb_flush: 1'b0};

endpackage

// File: rtl/pipe_hazard_sequencer_if.sv
// rtl/pipe_hazard_sequencer_if.sv - hazard request and stage control bundle
interface pipe_hazard_sequencer_if #(
  parameter int CNT_W = 32
);
  logic             i_load_use;
  logic             i_br_taken_ex;
  logic             i_mem_req;
  logic             i_mem_ready;
  logic             i_halt_req;
  logic             i_resume;
  logic             o_pc_en;
  logic             o_if_id_en;
  logic             o_if_id_flush;
  logic             o_id_ex_en;
  logic             o_id_ex_flush;
  logic             o_ex_mem_en;
  logic             o_mem_wb_flush;
  logic             o_mem_err;
  logic             o_halted;
  logic [1:0]       o_state;
  logic [CNT_W-1:0] o_stall_cnt;
  logic [CNT_W-1:0] o_flush_cnt;

  // Pipeline side: raises hazard requests, consumes stage controls.
  modport master (
    output i_load_use, i_br_taken_ex, i_mem_req, i_mem_ready, i_halt_req, i_resume,
    input  o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_ex_mem_en, o_mem_wb_flush, o_mem_err, o_halted, o_state,
           o_stall_cnt, o_flush_cnt
  );

  // Sequencer side.
  modport slave (
    input  i_load_use, i_br_taken_ex, i_mem_req, i_mem_ready, i_halt_req, i_resume,
    output o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush,
           o_ex_mem_en, o_mem_wb_flush, o_mem_err, o_halted, o_state,
           o_stall_cnt, o_flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_sequencer_sat_counter.sv
// rtl/pipe_hazard_sequencer_sat_counter.sv - saturating event counter
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_sequencer.sv
// rtl/pipe_hazard_sequencer.sv - stall/flush scheduler for the 5-stage pipeline
module pipe_hazard_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 16,
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input logic                    i_clk,
  input logic                    i_reset,
  pipe_hazard_sequencer_if.slave hz
);

  localparam logic [1:0] S_RUN      = RUN;
  localparam logic [1:0] S_MEM_WAIT = MEM_WAIT;
  localparam logic [1:0] S_DRAIN    = DRAIN;
  localparam logic [1:0] S_HALTED   = HALTED;

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  logic [1:0]         state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  stage_ctrl_t        ctl;
  logic               mem_err;
  logic               halted;
  logic               stall_inc;
  logic               flush_inc;
  logic               mem_stall;

  assign mem_stall = hz.i_mem_req & ~hz.i_mem_ready;

  // Priority resolution of the hazard sources and next-state selection.
  always_comb begin
    ctl       = STAGE_RUN;
    mem_err   = 1'b0;
    halted    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    drain_nxt = drain_cnt;
    if (!i_reset) begin
      case (state)
        S_RUN: begin
          if (mem_stall) begin
            // Branch/load-use stay asserted while EX/ID are frozen; they are served later.
            ctl       = STAGE_FREEZE;
            stall_inc = 1'b1;
            state_nxt = S_MEM_WAIT;
            wait_nxt  = WAIT_W'(1);
          end else if (hz.i_br_taken_ex) begin
            ctl.if_id_flush = 1'b1;
            ctl.id_ex_flush = 1'b1;
            flush_inc       = 1'b1;
          end else if (hz.i_load_use) begin
            ctl.pc_en       = 1'b0;
            ctl.if_id_en    = 1'b0;
            ctl.id_ex_flush = 1'b1;
            stall_inc       = 1'b1;
          end else if (hz.i_halt_req) begin
            state_nxt = S_DRAIN;
            drain_nxt = '0;
          end
        end
        S_MEM_WAIT: begin
          if (hz.i_mem_ready) begin
            state_nxt = S_RUN;
            wait_nxt  = '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            // Give up on the access: report it and drop it from MEM/WB.
            mem_err          = 1'b1;
            ctl.mem_wb_flush = 1'b1;
            state_nxt        = S_RUN;
            wait_nxt         = '0;
          end else begin
            ctl       = STAGE_FREEZE;
            stall_inc = 1'b1;
            wait_nxt  = wait_cnt + WAIT_W'(1);
          end
        end
        S_DRAIN: begin
          ctl.pc_en       = 1'b0;
          ctl.if_id_flush = 1'b1;
          if (mem_stall) begin
            ctl       = STAGE_FREEZE;
            stall_inc = 1'b1;
          end else if (hz.i_load_use && !hz.i_br_taken_ex) begin
            // Keep the dependent instruction in ID instead of squashing it; drain holds.
            ctl.if_id_flush = 1'b0;
            ctl.if_id_en    = 1'b0;
            ctl.id_ex_flush = 1'b1;
            stall_inc       = 1'b1;
          end else begin
            if (hz.i_br_taken_ex) begin
              ctl.id_ex_flush = 1'b1;
              flush_inc       = 1'b1;
            end
            if (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1)) begin
              state_nxt = S_HALTED;
              drain_nxt = '0;
            end else begin
              drain_nxt = drain_cnt + DRAIN_W'(1);
            end
          end
        end
        S_HALTED: begin
          ctl    = STAGE_HOLD;
          halted = 1'b1;
          if (hz.i_resume) begin
            state_nxt = S_RUN;
          end
        end
        default: state_nxt = S_RUN;
      endcase
    end
  end

  // State and sequencing counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= S_RUN;
      wait_cnt  <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .clear (i_reset),
    .inc   (stall_inc),
    .count (hz.o_stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .clear (i_reset),
    .inc   (flush_inc),
    .count (hz.o_flush_cnt)
  );

  assign hz.o_pc_en        = ctl.pc_en;
  assign hz.o_if_id_en     = ctl.if_id_en;
  assign hz.o_if_id_flush  = ctl.if_id_flush;
  assign hz.o_id_ex_en     = ctl.id_ex_en;
  assign hz.o_id_ex_flush  = ctl.id_ex_flush;
  assign hz.o_ex_mem_en    = ctl.ex_mem_en;
  assign hz.o_mem_wb_flush = ctl.mem_wb_flush;
  assign hz.o_mem_err      = mem_err;
  assign hz.o_halted       = halted;
  assign hz.o_state        = state;

endmodule

// File: tb/tb_pipe_hazard_sequencer.sv
// tb/tb_pipe_hazard_sequencer.sv - directed self-checking bench for the hazard sequencer
module tb_pipe_hazard_sequencer;

  localparam int CNT_W = 4;

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush}
  localparam logic [6:0] C_RUN    = 7'b1101010;
  localparam logic [6:0] C_FREEZE = 7'b0000001;
  localparam logic [6:0] C_LU     = 7'b0001110;
  localparam logic [6:0] C_BR     = 7'b1111110;
  localparam logic [6:0] C_DRAIN  = 7'b0111010;
  localparam logic [6:0] C_HOLD   = 7'b0000000;
  localparam logic [6:0] C_ABORT  = 7'b1101011;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   good;

  pipe_hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_sequencer #(
    .MEM_TIMEOUT  (16),
    .DRAIN_CYCLES (4),
    .CNT_W        (CNT_W)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .hz      (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl_v();
    return {bus.o_pc_en, bus.o_if_id_en, bus.o_if_id_flush, bus.o_id_ex_en,
            bus.o_id_ex_flush, bus.o_ex_mem_en, bus.o_mem_wb_flush};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_load_use    = 1'b0;
    bus.i_br_taken_ex = 1'b0;
    bus.i_mem_req     = 1'b0;
    bus.i_mem_ready   = 1'b0;
    bus.i_halt_req    = 1'b0;
    bus.i_resume      = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    chk("reset_state", 32'(bus.o_state), 32'd0);
    chk("reset_stall", 32'(bus.o_stall_cnt), 32'd0);
    chk("reset_flush", 32'(bus.o_flush_cnt), 32'd0);
    @(negedge clk);
    chk("reset_ctl", 32'(ctl_v()), 32'(C_RUN));

    // Reset while stalled in MEM_WAIT
    rst = 1'b0;
    bus.i_mem_req = 1'b1;
    cyc();
    chk("mw_enter_state", 32'(bus.o_state), 32'd1);
    cyc();
    chk("mw_stall2", 32'(bus.o_stall_cnt), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mw_rst_ctl", 32'(ctl_v()), 32'(C_RUN));
    chk("mw_rst_err", 32'(bus.o_mem_err), 32'd0);
    cyc();
    rst = 1'b0;
    bus.i_mem_req = 1'b0;
    @(negedge clk);
    chk("mw_rel_state", 32'(bus.o_state), 32'd0);
    chk("mw_rel_stall", 32'(bus.o_stall_cnt), 32'd0);
    chk("mw_rel_ctl", 32'(ctl_v()), 32'(C_RUN));

    // Single load-use bubble
    do_reset();
    bus.i_load_use = 1'b1;
    @(negedge clk);
    chk("lu_ctl", 32'(ctl_v()), 32'(C_LU));
    cyc();
    bus.i_load_use = 1'b0;
    chk("lu_stall", 32'(bus.o_stall_cnt), 32'd1);
    chk("lu_state", 32'(bus.o_state), 32'd0);
    @(negedge clk);
    chk("lu_after_ctl", 32'(ctl_v()), 32'(C_RUN));

    // Branch beats load-use
    do_reset();
    bus.i_br_taken_ex = 1'b1;
    bus.i_load_use    = 1'b1;
    @(negedge clk);
    chk("brlu_ctl", 32'(ctl_v()), 32'(C_BR));
    cyc();
    idle_inputs();
    chk("brlu_flush", 32'(bus.o_flush_cnt), 32'd1);
    chk("brlu_stall", 32'(bus.o_stall_cnt), 32'd0);

    // Memory stall of three cycles with a pending branch
    do_reset();
    bus.i_mem_req     = 1'b1;
    bus.i_br_taken_ex = 1'b1;
    good = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ctl_v() == C_FREEZE) good++;
      cyc();
    end
    chk("ms_frozen_cycles", 32'(good), 32'd3);
    chk("ms_stall3", 32'(bus.o_stall_cnt), 32'd3);
    chk("ms_wait_state", 32'(bus.o_state), 32'd1);
    bus.i_mem_ready = 1'b1;
    @(negedge clk);
    chk("ms_ready_ctl", 32'(ctl_v()), 32'(C_RUN));
    cyc();
    bus.i_mem_req   = 1'b0;
    bus.i_mem_ready = 1'b0;
    chk("ms_back_run", 32'(bus.o_state), 32'd0);
    chk("ms_ready_not_counted", 32'(bus.o_stall_cnt), 32'd3);
    @(negedge clk);
    chk("ms_br_ctl", 32'(ctl_v()), 32'(C_BR));
    cyc();
    bus.i_br_taken_ex = 1'b0;
    chk("ms_flush1", 32'(bus.o_flush_cnt), 32'd1);

    // Memory timeout; stall count passes 15 and must saturate
    do_reset();
    bus.i_mem_req = 1'b1;
    cyc();
    good = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.o_mem_err == 1'b0 && ctl_v() == C_FREEZE && bus.o_state == 2'd1) good++;
      cyc();
    end
    chk("to_wait_cycles", 32'(good), 32'd15);
    @(negedge clk);
    chk("to_err", 32'(bus.o_mem_err), 32'd1);
    chk("to_abort_ctl", 32'(ctl_v()), 32'(C_ABORT));
    cyc();
    bus.i_mem_req = 1'b0;
    chk("to_state_run", 32'(bus.o_state), 32'd0);
    chk("to_stall_sat", 32'(bus.o_stall_cnt), 32'd15);
    @(negedge clk);
    chk("to_err_once", 32'(bus.o_mem_err), 32'd0);

    // Halt drain, halt, resume, re-halt
    do_reset();
    bus.i_halt_req = 1'b1;
    @(negedge clk);
    chk("h_first_ctl", 32'(ctl_v()), 32'(C_RUN));
    cyc();
    good = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ctl_v() == C_DRAIN && bus.o_state == 2'd2 && !bus.o_halted) good++;
      cyc();
    end
    chk("h_drain_cycles", 32'(good), 32'd4);
    chk("h_state_halted", 32'(bus.o_state), 32'd3);
    @(negedge clk);
    chk("h_halted", 32'(bus.o_halted), 32'd1);
    chk("h_hold_ctl", 32'(ctl_v()), 32'(C_HOLD));
    cyc();
    chk("h_stays", 32'(bus.o_state), 32'd3);
    bus.i_resume = 1'b1;
    cyc();
    bus.i_resume = 1'b0;
    chk("h_resume_run", 32'(bus.o_state), 32'd0);
    @(negedge clk);
    chk("h_resume_halted_low", 32'(bus.o_halted), 32'd0);
    cyc();
    chk("h_rehalt", 32'(bus.o_state), 32'd2);

    // Stall counter saturation at 15
    do_reset();
    bus.i_load_use = 1'b1;
    for (int i = 0; i < 15; i++) cyc();
    chk("sat_at15", 32'(bus.o_stall_cnt), 32'd15);
    cyc();
    bus.i_load_use = 1'b0;
    chk("sat_hold15", 32'(bus.o_stall_cnt), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
